// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and tree-PLRU helpers for the N-way data-cache store.
// Contents: tag_t/line_t, entry_t {valid,dirty,tag}, sweep FSM states, plru_touch/plru_victim.
package dcache_pkg;

    localparam int DC_TAG_W  = 23;
    localparam int DC_LINE_W = 256;

    // Up to 8 ways -> at most 7 tree nodes, 3 levels.
    localparam int PLRU_MAXB = 7;

    typedef logic [DC_TAG_W-1:0]  tag_t;
    typedef logic [DC_LINE_W-1:0] line_t;
    typedef logic [PLRU_MAXB-1:0] plru_t;

    typedef struct packed {
        logic valid;
        logic dirty;
        tag_t tag;
    } entry_t;

    typedef enum logic {
        ST_IDLE,
        ST_SWEEP
    } sweep_state_e;

    // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right).
    // Node bit 1 means the victim lies in the right subtree.
    function automatic plru_t plru_touch(
        input plru_t      bits,
        input logic [2:0] way,
        input int         lvls
    );
        plru_t r;
        plru_t m;
        int    node;
        int    b;
        r    = bits;
        node = 0;
        for (int i = 0; i < 3; i++) begin
            if (i < lvls) begin
                b = (int'(way) >> (lvls - 1 - i)) & 1;
                m = plru_t'(1) << node;
                if (b == 1) r = r & ~m;
                else        r = r | m;
                node = 2 * node + 1 + b;
            end
        end
        return r;
    endfunction

    function automatic logic [2:0] plru_victim(
        input plru_t bits,
        input int    lvls
    );
        int node;
        int d;
        int v;
        node = 0;
        v    = 0;
        for (int i = 0; i < 3; i++) begin
            if (i < lvls) begin
                d    = (((bits >> node) & plru_t'(1)) != '0) ? 1 : 0;
                v    = (v << 1) | d;
                node = 2 * node + 1 + d;
            end
        end
        return 3'(v);
    endfunction

endpackage

// File: rtl/dcache_plru.sv
// dcache_plru: per-set tree-PLRU bits with touch, victim read and per-set clear.
// Ports: clk_i, rst_n_i, i_set (victim read set), i_touch/i_touch_way, i_clr/i_clr_set, o_victim.
module dcache_plru
    import dcache_pkg::*;
#(
    parameter int WAYS = 4,
    parameter int SETS = 16,
    localparam int WAY_W = $clog2(WAYS),
    localparam int SET_W = $clog2(SETS)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [SET_W-1:0] i_set,
    input  logic             i_touch,
    input  logic [WAY_W-1:0] i_touch_way,
    input  logic             i_clr,
    input  logic [SET_W-1:0] i_clr_set,
    output logic [WAY_W-1:0] o_victim
);

    logic [WAYS-2:0] r_bits [SETS];

    assign o_victim = WAY_W'(plru_victim(plru_t'(r_bits[i_set]), WAY_W));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int s = 0; s < SETS; s++) r_bits[s] <= '0;
        end else if (i_clr) begin
            r_bits[i_clr_set] <= '0;
        end else if (i_touch) begin
            r_bits[i_set] <= (WAYS-1)'(plru_touch(plru_t'(r_bits[i_set]),
                                                3'(i_touch_way), WAY_W));
        end
    end

endmodule

// File: rtl/dcache_sram_nway.sv
// dcache_sram_nway: N-way set-associative tag/data store, 1-cycle registered lookup,
// tree-PLRU replacement, valid/ready handshake and sequenced invalidate-all sweep.
// Ports: clk_i/rst_n_i; req_i/we_i/set_i/tag_i/dirty_i/data_i request; inv_all_i sweep start;
// ready_o, rsp_valid_o/hit_o/way_o/vic_valid_o/vic_dirty_o/tag_o/data_o response; hit_cnt_o/miss_cnt_o.
// Optional stats counters: define DCACHE_SRAM_STATS_EN.
module dcache_sram_nway
    import dcache_pkg::*;
#(
    parameter int WAYS   = 4,
    parameter int SETS   = 16,
    parameter int TAG_W  = DC_TAG_W,
    parameter int LINE_W = DC_LINE_W,
    localparam int WAY_W = $clog2(WAYS),
    localparam int SET_W = $clog2(SETS)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [SET_W-1:0]  set_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic              dirty_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              inv_all_i,
    output logic              ready_o,
    output logic              rsp_valid_o,
    output logic              hit_o,
    output logic [WAY_W-1:0]  way_o,
    output logic              vic_valid_o,
    output logic              vic_dirty_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [LINE_W-1:0] data_o,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
);

    logic [WAYS-1:0]   r_valid [SETS];
    logic [WAYS-1:0]   r_dirty [SETS];
    logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
    logic [LINE_W-1:0] r_data  [SETS][WAYS];

    sweep_state_e      r_state;
    sweep_state_e      w_state_nxt;
    logic [SET_W-1:0]  r_idx;
    logic [SET_W-1:0]  w_idx_nxt;
    logic              w_sweep;
    logic              w_ready;
    logic              w_accept;

    logic [WAYS-1:0]   w_hit_vec;
    logic              w_hit;
    logic [WAY_W-1:0]  w_hit_way;
    logic [WAY_W-1:0]  w_first_inv;
    logic              w_any_inv;
    logic [WAY_W-1:0]  w_plru_vic;
    logic [WAY_W-1:0]  w_sel_way;

    logic              r_rsp_valid;
    logic              r_hit;
    logic [WAY_W-1:0]  r_way;
    logic              r_vic_valid;
    logic              r_vic_dirty;
    logic [TAG_W-1:0]  r_tag_o;
    logic [LINE_W-1:0] r_data_o;

    // Sweep FSM
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_sweep     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (inv_all_i) begin
                    w_state_nxt = ST_SWEEP;
                    w_idx_nxt   = '0;
                end
            end
            ST_SWEEP: begin
                w_sweep   = 1'b1;
                w_idx_nxt = r_idx + 1'b1;
                if (r_idx == SET_W'(SETS - 1)) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_ready  = (r_state == ST_IDLE);
    // A request in the sweep-start cycle is dropped.
    assign w_accept = req_i && w_ready && !inv_all_i;

    // Tag compare and way selection
    always_comb begin
        w_hit_vec   = '0;
        w_hit_way   = '0;
        w_first_inv = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_hit_vec[w] = r_valid[set_i][w] && (r_tag[set_i][w] == tag_i);
            if (w_hit_vec[w]) w_hit_way = WAY_W'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[set_i][w]) w_first_inv = WAY_W'(w);
        end
    end

    assign w_hit     = |w_hit_vec;
    assign w_any_inv = ~&r_valid[set_i];
    assign w_sel_way = w_hit     ? w_hit_way   :
                       w_any_inv ? w_first_inv : w_plru_vic;

    dcache_plru #(
        .WAYS(WAYS),
        .SETS(SETS)
    ) u_plru (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .i_set      (set_i),
        .i_touch    (w_accept && (we_i || w_hit)),
        .i_touch_way(w_sel_way),
        .i_clr      (w_sweep),
        .i_clr_set  (r_idx),
        .o_victim   (w_plru_vic)
    );

    // Valid/dirty bits
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
            end
        end else if (w_sweep) begin
            r_valid[r_idx] <= '0;
            r_dirty[r_idx] <= '0;
        end else if (w_accept && we_i) begin
            r_valid[set_i][w_sel_way] <= 1'b1;
            r_dirty[set_i][w_sel_way] <= dirty_i;
        end
    end

    // Tag/data arrays carry no reset; valid bits gate them.
    always_ff @(posedge clk_i) begin
        if (w_accept && we_i) begin
            r_tag[set_i][w_sel_way]  <= tag_i;
            r_data[set_i][w_sel_way] <= data_i;
        end
    end

    // Registered response
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rsp_valid <= 1'b0;
            r_hit       <= 1'b0;
            r_way       <= '0;
            r_vic_valid <= 1'b0;
            r_vic_dirty <= 1'b0;
            r_tag_o     <= '0;
            r_data_o    <= '0;
        end else begin
            r_rsp_valid <= w_accept && !we_i;
            if (w_accept && !we_i) begin
                r_hit       <= w_hit;
                r_way       <= w_sel_way;
                r_vic_valid <= !w_hit && r_valid[set_i][w_sel_way];
                r_vic_dirty <= !w_hit && r_dirty[set_i][w_sel_way];
                r_tag_o     <= r_tag[set_i][w_sel_way];
                r_data_o    <= r_data[set_i][w_sel_way];
            end
        end
    end

    assign ready_o     = w_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign hit_o       = r_hit;
    assign way_o       = r_way;
    assign vic_valid_o = r_vic_valid;
    assign vic_dirty_o = r_vic_dirty;
    assign tag_o       = r_tag_o;
    assign data_o      = r_data_o;

`ifdef DCACHE_SRAM_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;
    logic        w_inv_start;

    assign w_inv_start = w_ready && inv_all_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_inv_start) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_accept && !we_i) begin
            if (w_hit) begin
                if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 32'd1;
            end else begin
                if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dcache_sram_nway.sv
// tb_dcache_sram_nway: directed self-checking bench for dcache_sram_nway (default params).
// Honours DCACHE_SRAM_STATS_EN when computing expected counter values.
module tb_dcache_sram_nway;
    import dcache_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [3:0]  set;
    tag_t        tag;
    logic        dirty;
    line_t       data;
    logic        inv_all;
    logic        ready;
    logic        rsp_valid;
    logic        hit;
    logic [1:0]  way;
    logic        vic_valid;
    logic        vic_dirty;
    tag_t        tag_out;
    line_t       data_out;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int n_vec = 0;
    int n_err = 0;
    int exp_hits = 0;
    int exp_miss = 0;

    always #5 clk = ~clk;

    dcache_sram_nway dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .req_i      (req),
        .we_i       (we),
        .set_i      (set),
        .tag_i      (tag),
        .dirty_i    (dirty),
        .data_i     (data),
        .inv_all_i  (inv_all),
        .ready_o    (ready),
        .rsp_valid_o(rsp_valid),
        .hit_o      (hit),
        .way_o      (way),
        .vic_valid_o(vic_valid),
        .vic_dirty_o(vic_dirty),
        .tag_o      (tag_out),
        .data_o     (data_out),
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt)
    );

    function automatic line_t mkline(input logic [7:0] t);
        return {8{24'hC0DE5A, t}};
    endfunction

    function automatic logic [31:0] exp_cnt(input int v);
`ifdef DCACHE_SRAM_STATS_EN
        return 32'(v);
`else
        return 32'(v) & 32'd0;
`endif
    endfunction

    task automatic chk(input string tg, input logic [255:0] obs,
                       input logic [255:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tg, obs, exp);
        end
    endtask

    task automatic lookup(input logic [3:0] s, input tag_t t);
        req = 1'b1;
        we  = 1'b0;
        set = s;
        tag = t;
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    task automatic write(input logic [3:0] s, input tag_t t,
                         input logic d, input line_t l);
        req   = 1'b1;
        we    = 1'b1;
        set   = s;
        tag   = t;
        dirty = d;
        data  = l;
        @(posedge clk);
        #1;
        req = 1'b0;
        we  = 1'b0;
    endtask

    task automatic chk_rsp(input string tg, input logic h, input logic [1:0] w,
                           input logic vv, input logic vd);
        chk({tg, ".rsp_valid"}, 256'(rsp_valid), 256'(1'b1));
        chk({tg, ".hit"},       256'(hit),       256'(h));
        chk({tg, ".way"},       256'(way),       256'(w));
        chk({tg, ".vic_valid"}, 256'(vic_valid), 256'(vv));
        chk({tg, ".vic_dirty"}, 256'(vic_dirty), 256'(vd));
    endtask

    task automatic chk_cnt(input string tg);
        chk({tg, ".hit_cnt"},  256'(hit_cnt),  256'(exp_cnt(exp_hits)));
        chk({tg, ".miss_cnt"}, 256'(miss_cnt), 256'(exp_cnt(exp_miss)));
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = 1'b0;
        we      = 1'b0;
        set     = '0;
        tag     = '0;
        dirty   = 1'b0;
        data    = '0;
        inv_all = 1'b0;
        #1;
        chk("rst.ready",     256'(ready),     256'(1'b1));
        chk("rst.rsp_valid", 256'(rsp_valid), 256'(1'b0));
        chk("rst.hit",       256'(hit),       256'(1'b0));
        chk("rst.way",       256'(way),       256'(2'd0));
        chk_cnt("rst");
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Cold miss on an empty set
        lookup(4'd3, tag_t'(23'h1A));
        exp_miss++;
        chk_rsp("cold", 1'b0, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("cold.rsp_drop", 256'(rsp_valid), 256'(1'b0));

        // Fill ways 0..3 via first-invalid
        for (int i = 0; i < 4; i++)
            write(4'd3, tag_t'(23'h10 + i), 1'b0, mkline(8'h10 + 8'(i)));

        lookup(4'd3, tag_t'(23'h12));
        exp_hits++;
        chk_rsp("hit12", 1'b1, 2'd2, 1'b0, 1'b0);
        chk("hit12.tag",  256'(tag_out), 256'(23'h12));
        chk("hit12.data", 256'(data_out), 256'(mkline(8'h12)));

        // Touch order 0,1,2,3 -> PLRU victim is way 0
        for (int i = 0; i < 4; i++) begin
            lookup(4'd3, tag_t'(23'h10 + i));
            exp_hits++;
            chk("touch.way", 256'(way), 256'(i));
        end
        write(4'd3, tag_t'(23'h20), 1'b0, mkline(8'h20));
        lookup(4'd3, tag_t'(23'h20));
        exp_hits++;
        chk_rsp("fill20", 1'b1, 2'd0, 1'b0, 1'b0);

        // Miss: tree root right, node2 left -> way 2
        lookup(4'd3, tag_t'(23'h30));
        exp_miss++;
        chk_rsp("miss30", 1'b0, 2'd2, 1'b1, 1'b0);
        chk("miss30.tag",  256'(tag_out), 256'(23'h12));
        chk("miss30.data", 256'(data_out), 256'(mkline(8'h12)));

        // Dirty write-hit on way 1, then steer PLRU to way 1
        write(4'd3, tag_t'(23'h11), 1'b1, mkline(8'h91));
        lookup(4'd3, tag_t'(23'h20));
        exp_hits++;
        lookup(4'd3, tag_t'(23'h12));
        exp_hits++;
        lookup(4'd3, tag_t'(23'h40));
        exp_miss++;
        chk_rsp("miss40", 1'b0, 2'd1, 1'b1, 1'b1);
        chk("miss40.tag",  256'(tag_out), 256'(23'h11));
        chk("miss40.data", 256'(data_out), 256'(mkline(8'h91)));

        // Other set untouched
        lookup(4'd4, tag_t'(23'h10));
        exp_miss++;
        chk_rsp("set4", 1'b0, 2'd0, 1'b0, 1'b0);
        chk_cnt("pre_inv");

        // Invalidate-all; the coincident lookup is dropped
        inv_all = 1'b1;
        req = 1'b1;
        we = 1'b0;
        set = 4'd3;
        tag = tag_t'(23'h12);
        @(posedge clk);
        #1;
        inv_all = 1'b0;
        exp_hits = 0;
        exp_miss = 0;
        chk("inv.ready0", 256'(ready), 256'(1'b0));
        chk("inv.rsp0",   256'(rsp_valid), 256'(1'b0));
        for (int k = 1; k < 16; k++) begin
            req = 1'b1;
            we = k[0];
            set = 4'd5;
            tag = tag_t'(23'h55);
            dirty = 1'b1;
            @(posedge clk);
            #1;
            chk("sweep.ready", 256'(ready), 256'(1'b0));
            chk("sweep.rsp",   256'(rsp_valid), 256'(1'b0));
        end
        req = 1'b0;
        we = 1'b0;
        @(posedge clk);
        #1;
        chk("sweep.done", 256'(ready), 256'(1'b1));
        chk("sweep.rsp_end", 256'(rsp_valid), 256'(1'b0));
        chk_cnt("post_inv");

        lookup(4'd3, tag_t'(23'h12));
        exp_miss++;
        chk_rsp("inv12", 1'b0, 2'd0, 1'b0, 1'b0);
        lookup(4'd5, tag_t'(23'h55));
        exp_miss++;
        chk_rsp("inv55", 1'b0, 2'd0, 1'b0, 1'b0);

        write(4'd1, tag_t'(23'h7), 1'b0, mkline(8'h07));
        for (int i = 0; i < 3; i++) begin
            lookup(4'd1, tag_t'(23'h7));
            exp_hits++;
        end
        chk_rsp("s1hit", 1'b1, 2'd0, 1'b0, 1'b0);
        chk_cnt("stats32");

        // Reset mid-sweep
        inv_all = 1'b1;
        @(posedge clk);
        #1;
        inv_all = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midsw.busy", 256'(ready), 256'(1'b0));
        rst_n = 1'b0;
        #1;
        exp_hits = 0;
        exp_miss = 0;
        chk("midsw.ready", 256'(ready), 256'(1'b1));
        chk("midsw.rsp",   256'(rsp_valid), 256'(1'b0));
        chk_cnt("midsw");
        #1;
        rst_n = 1'b1;

        // Reset mid-lookup
        write(4'd2, tag_t'(23'h2B), 1'b1, mkline(8'h2B));
        lookup(4'd2, tag_t'(23'h2B));
        chk("midlk.rsp1", 256'(rsp_valid), 256'(1'b1));
        rst_n = 1'b0;
        #1;
        chk("midlk.rsp0", 256'(rsp_valid), 256'(1'b0));
        chk("midlk.hit0", 256'(hit), 256'(1'b0));
        #1;
        rst_n = 1'b1;
        lookup(4'd2, tag_t'(23'h2B));
        exp_miss++;
        chk_rsp("after_rst", 1'b0, 2'd0, 1'b0, 1'b0);
        chk_cnt("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        n_err++;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
